bilateral_scheduler: RTL and testbench
======================================

Name: bilateral_scheduler

Overview:
- Frame-level controller that sequences the 7x7 bilateral filter pipeline.
- Accepts a valid/ready stream of local windows, issues one window per cycle into the filter (no backpressure, fixed LATENCY), and captures filtered pixels into an internal FIFO.
- Issue is credit-gated: filter output can never overflow the FIFO.
- Presents results downstream as valid/ready with frame-end marking, start/busy/done control and a sticky error flag.

Parameters:
- LATENCY, 30, fixed filter latency in cycles, window valid in to pixel valid out.
- FIFO_DEPTH, 32, result FIFO entries; must be >= 2.
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse; frame fully drained downstream.
- err  out  1  sticky protocol error; cleared only by rst.
- win_valid  in  1  upstream window available. Window data routes directly to the filter.
- win_ready  out  1  scheduler accepts the window this cycle.
- filt_valid  out  1  window valid to filter; equals win_valid & win_ready.
- filt_pixel  in  10  filter result.
- filt_pixel_valid  in  1  filter result valid.
- out_pixel  out  10  FIFO head pixel.
- out_last  out  1  head is the final pixel of the frame.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts.

Behaviour:
- Reset values: busy=0, done=0, err=0, win_ready=0, filt_valid=0, out_valid=0, out_last=0, out_pixel=0. All counters and the FIFO are cleared.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN; clear the issue counter (x,y), the return counter and the output counter.
  - RUN: win_ready = (credits > 0) when the issue count is below IMG_W*IMG_H. When the last window issues, go to DRAIN.
  - DRAIN: win_ready=0. When inflight==0, FIFO is empty, and the output count equals IMG_W*IMG_H, go to DONE.
  - DONE: done=1 for one cycle, then IDLE. busy=1 in RUN, DRAIN and DONE.
- start outside IDLE is ignored.
- Issue and capture:
  - win_ready is combinational from registered state and counters only; it never depends on win_valid.
  - An issue occurs on win_valid & win_ready.
  - inflight: +1 on issue, -1 on filt_pixel_valid; unchanged when both happen in the same cycle.
  - credits = FIFO_DEPTH - fifo_count - inflight. Evaluate with registered values and no look-ahead on same-cycle pops; this is conservative.
  - filt_pixel_valid pushes filt_pixel into the FIFO.
  - A push while full, or filt_pixel_valid while inflight==0 outside the flush window: set err and drop the data.
- Output:
  - First-word-fall-through FIFO. A pop occurs on out_valid & out_ready.
  - Push and pop in the same cycle keep fifo_count unchanged; this is legal when full or empty only if the order is consistent (empty: no bypass, the pushed data appears the next cycle).
  - out_last is a tag bit stored with each entry. It is set on the push whose return count equals IMG_W*IMG_H-1.
  - out_valid/out_pixel stay stable while out_ready=0.
- Counters:
  - x wraps at IMG_W-1 and increments y.
  - y wraps at IMG_H-1. Only issue counting uses x,y.
  - Widths are $clog2 of the respective maxima.
  - credits/inflight are $clog2(FIFO_DEPTH+1) bits.
- Reset mid-frame:
  - All state returns to IDLE.
  - A flush counter is loaded with LATENCY. While it is nonzero, filt_pixel_valid is silently discarded: no err, no push.
  - start is ignored until the flush counter reaches 0.

Test Plan:
- IMG_W=4, IMG_H=2, LATENCY=3 delay model, FIFO_DEPTH=4, out_ready=1, win_valid=1, start pulse -> 8 issues, 8 outputs in order, out_last only on the 8th, done one cycle after the last pop, err=0.
- Same setup, out_ready=0 after start -> exactly 4 issues, then win_ready=0. Raise out_ready -> remaining 4 issue; the FIFO never exceeds 4 and err=0.
- Same config, win_valid toggled 1/0 each cycle and out_ready random with a fixed seed -> output sequence matches the issue order, the total is 8, and busy drops with done.
- Inject filt_pixel_valid with no prior issue while in IDLE after the flush window -> err=1 and stays 1 until rst; no output.
- Assert rst for one cycle after the 5th issue, with 3 results still in flight -> the in-flight results are discarded with err=0; start within 3 cycles of reset is ignored; a later start runs a clean 8-pixel frame.
- start pulse while in RUN -> no effect; the frame completes with exactly 8 outputs and a single done pulse.

Source files
------------

// File: rtl/bilateral_scheduler.sv
// Frame sequencer for the 7x7 bilateral filter: credit-gated window issue,
// result capture into a first-word-fall-through FIFO, and frame start/done control.
`timescale 1ns/1ps
module bilateral_scheduler #(
  parameter int LATENCY    = 30,
  parameter int FIFO_DEPTH = 32,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       win_valid,
  output logic       win_ready,
  output logic       filt_valid,
  input  logic [9:0] filt_pixel,
  input  logic       filt_pixel_valid,
  output logic [9:0] out_pixel,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NW    = $clog2(TOTAL + 1);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int FW    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [XW-1:0] X_MAX    = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(IMG_H - 1);
  localparam logic [NW-1:0] TOTAL_C  = NW'(TOTAL);
  localparam logic [NW-1:0] TOTAL_M1 = NW'(TOTAL - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_MAX  = PW'(FIFO_DEPTH - 1);
  localparam logic [FW-1:0] FLUSH_C  = FW'(LATENCY);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [NW-1:0] ret_cnt, out_cnt;
  logic [CW-1:0] inflight, fifo_count;
  logic [FW-1:0] flush;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [10:0]   mem [FIFO_DEPTH];

  logic [CW:0] used;
  logic issue, last_issue, pop, full, ret, push, stray, start_ok;

  // Credits are FIFO_DEPTH - used; a window may issue only while used < FIFO_DEPTH.
  assign used       = {1'b0, fifo_count} + {1'b0, inflight};
  assign win_ready  = (state == RUN) && (used < DEPTH_W);
  assign filt_valid = win_valid & win_ready;
  assign issue      = filt_valid;
  assign last_issue = issue && (x == X_MAX) && (y == Y_MAX);

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (fifo_count == DEPTH_C);
  assign out_pixel = out_valid ? mem[rd_ptr][9:0] : '0;
  assign out_last  = out_valid & mem[rd_ptr][10];

  // Results arriving during the post-reset flush window are dropped silently.
  assign ret   = filt_pixel_valid && (flush == '0) && (inflight != '0);
  assign push  = ret && (!full || pop);
  assign stray = filt_pixel_valid && (flush == '0) && ((inflight == '0) || (full && !pop));

  assign start_ok = start && (state == IDLE) && (flush == '0);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if ((inflight == '0) && (fifo_count == '0) && (out_cnt == TOTAL_C)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      ret_cnt    <= '0;
      out_cnt    <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      err        <= 1'b0;
      flush      <= FLUSH_C;
    end else begin
      state <= state_nxt;
      if (flush != '0) flush <= flush - 1'b1;
      if (stray) err <= 1'b1;

      if (start_ok) begin
        x       <= '0;
        y       <= '0;
        ret_cnt <= '0;
        out_cnt <= '0;
      end else begin
        if (issue) begin
          if (x == X_MAX) begin
            x <= '0;
            y <= (y == Y_MAX) ? '0 : y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
        if (push) ret_cnt <= ret_cnt + 1'b1;
        if (pop)  out_cnt <= out_cnt + 1'b1;
      end

      if (issue && !ret)      inflight <= inflight + 1'b1;
      else if (!issue && ret) inflight <= inflight - 1'b1;

      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;

      if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {(ret_cnt == TOTAL_M1), filt_pixel};
  end

endmodule

// File: tb/tb_bilateral_scheduler.sv
// Self-checking bench for bilateral_scheduler: fixed-latency filter model plus an
// issue-order scoreboard (output must equal issue order, last tag on the 8th pixel).
`timescale 1ns/1ps
module tb_bilateral_scheduler;
  localparam int LAT = 3, DEPTH = 4, W = 4, H = 2, N = W * H;

  logic clk = 0, rst = 1, start = 0, win_valid = 0, out_ready = 0;
  logic busy, done, err, win_ready, filt_valid, out_last, out_valid;
  logic [9:0] filt_pixel = '0, out_pixel;
  logic filt_pixel_valid = 0;
  bit inject = 0;

  bilateral_scheduler #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .win_valid(win_valid), .win_ready(win_ready), .filt_valid(filt_valid),
    .filt_pixel(filt_pixel), .filt_pixel_valid(filt_pixel_valid),
    .out_pixel(out_pixel), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  bit pv_pipe [LAT+1];
  bit [9:0] px_pipe [LAT+1];
  logic [10:0] exp_q [$];
  logic [10:0] obs_q [$];
  int cyc = 0, issue_idx = 0, issued = 0, popped = 0, fr_issues = 0, max_occ = 0;
  int done_cnt = 0, done_cyc = 0, last_pop_cyc = 0, stable_viol = 0, hs_viol = 0;
  logic busy_after_done = 1;
  bit prev_done = 0, hold_prev = 0;
  logic [10:0] prev_out = '0;
  int n_cmp = 0, n_fail = 0;

  // Mid-cycle observer: filter delay line, scoreboard capture, protocol watchers.
  always @(negedge clk) begin
    cyc++;
    for (int k = LAT; k > 0; k--) begin
      pv_pipe[k] = pv_pipe[k-1];
      px_pipe[k] = px_pipe[k-1];
    end
    pv_pipe[0] = filt_valid;
    px_pipe[0] = 10'($urandom);
    if (rst) begin
      exp_q.delete();
      issue_idx = 0; issued = 0; popped = 0;
    end else begin
      if (filt_valid) begin
        exp_q.push_back({(issue_idx == N - 1), px_pipe[0]});
        issue_idx = (issue_idx + 1) % N;
        issued++; fr_issues++;
      end
      if (out_valid && out_ready) begin
        obs_q.push_back({out_last, out_pixel});
        popped++; last_pop_cyc = cyc;
      end
      if (issued - popped > max_occ) max_occ = issued - popped;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (prev_done) busy_after_done = busy;
      if (hold_prev && (!out_valid || {out_last, out_pixel} !== prev_out)) stable_viol++;
      if (filt_valid !== (win_valid & win_ready)) hs_viol++;
    end
    prev_done = done;
    hold_prev = out_valid && !out_ready;
    prev_out  = {out_last, out_pixel};
    filt_pixel_valid = pv_pipe[LAT] | inject;
    filt_pixel       = px_pipe[LAT];
  end

  task automatic clear_stats();
    obs_q.delete(); exp_q.delete();
    fr_issues = 0; max_occ = 0; done_cnt = 0; stable_viol = 0; hs_viol = 0;
    busy_after_done = 1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cycles(1); start = 1;
    cycles(1); start = 0;
  endtask

  task automatic wait_done(input int mode, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      cycles(1);
      if (mode == 1) begin win_valid = ~win_valid; out_ready = 1'($urandom); end
      if (done_cnt > 0) begin ok = 1; break; end
    end
    cycles(3);
    win_valid = 1; out_ready = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    cycles(2);
    @(negedge clk);
    n_cmp++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %b want 000", {busy, done, err}); end
    n_cmp++; if ({win_ready, filt_valid} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_issue: got %b want 00", {win_ready, filt_valid}); end
    n_cmp++; if ({out_valid, out_last, out_pixel} !== 12'h000) begin n_fail++; $display("[TB] FAIL reset_out: got %h want 000", {out_valid, out_last, out_pixel}); end
    cycles(1); rst = 0;
    cycles(6);
  endtask

  task automatic test_basic();
    bit ok, timing_ok;
    clear_stats();
    win_valid = 1; out_ready = 1;
    pulse_start();
    wait_done(0, 200, ok);
    timing_ok = (done_cyc > last_pop_cyc) && (done_cyc <= last_pop_cyc + 2);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_timeout: got %0d want 1", ok); end
    n_cmp++; if (fr_issues !== N) begin n_fail++; $display("[TB] FAIL basic_issues: got %0d want %0d", fr_issues, N); end
    n_cmp++; if (obs_q.size() !== N) begin n_fail++; $display("[TB] FAIL basic_count: got %0d want %0d", obs_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("[TB] FAIL basic_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    n_cmp++; if (timing_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_done_timing: got done@%0d want within 2 after pop@%0d", done_cyc, last_pop_cyc); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_err: got %b want 0", err); end
    n_cmp++; if (hs_viol !== 0) begin n_fail++; $display("[TB] FAIL basic_filt_valid: got %0d bad cycles want 0", hs_viol); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_stats();
    win_valid = 1; out_ready = 0;
    pulse_start();
    cycles(30);
    @(negedge clk);
    n_cmp++; if (fr_issues !== DEPTH) begin n_fail++; $display("[TB] FAIL bp_stalled_issues: got %0d want %0d", fr_issues, DEPTH); end
    n_cmp++; if (win_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_win_ready: got %b want 0", win_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_out_valid: got %b want 1", out_valid); end
    cycles(1); out_ready = 1;
    wait_done(0, 200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_timeout: got %0d want 1", ok); end
    n_cmp++; if (fr_issues !== N) begin n_fail++; $display("[TB] FAIL bp_issues: got %0d want %0d", fr_issues, N); end
    n_cmp++; if (obs_q.size() !== N) begin n_fail++; $display("[TB] FAIL bp_count: got %0d want %0d", obs_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("[TB] FAIL bp_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++; if (max_occ > DEPTH) begin n_fail++; $display("[TB] FAIL bp_occupancy: got %0d want <= %0d", max_occ, DEPTH); end
    n_cmp++; if (stable_viol !== 0) begin n_fail++; $display("[TB] FAIL bp_hold_stable: got %0d changes want 0", stable_viol); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_err: got %b want 0", err); end
  endtask

  task automatic test_random_flow();
    bit ok;
    clear_stats();
    win_valid = 1; out_ready = 1'($urandom);
    pulse_start();
    wait_done(1, 600, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rnd_timeout: got %0d want 1", ok); end
    n_cmp++; if (obs_q.size() !== N) begin n_fail++; $display("[TB] FAIL rnd_count: got %0d want %0d", obs_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("[TB] FAIL rnd_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++; if (busy_after_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_busy_after_done: got %b want 0", busy_after_done); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL rnd_done_pulses: got %0d want 1", done_cnt); end
    n_cmp++; if (stable_viol !== 0) begin n_fail++; $display("[TB] FAIL rnd_hold_stable: got %0d changes want 0", stable_viol); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_err: got %b want 0", err); end
  endtask

  task automatic test_stray_pixel();
    clear_stats();
    win_valid = 0;
    cycles(1); inject = 1;
    cycles(1); inject = 0;
    cycles(3);
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL stray_err: got %b want 1", err); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stray_out_valid: got %b want 0", out_valid); end
    cycles(10);
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL stray_err_sticky: got %b want 1", err); end
    n_cmp++; if (obs_q.size() !== 0) begin n_fail++; $display("[TB] FAIL stray_outputs: got %0d want 0", obs_q.size()); end
    win_valid = 1;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    cycles(1); rst = 1;
    cycles(1); rst = 0;
    cycles(6);
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_err_clear: got %b want 0", err); end
    clear_stats();
    win_valid = 1; out_ready = 1;
    pulse_start();
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (fr_issues >= 5) begin ok = 1; break; end
      cycles(1);
    end
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_reach_5: got %0d issues want 5", fr_issues); end
    rst = 1;
    cycles(1); rst = 0; start = 1;
    obs_q.delete();
    cycles(1); start = 0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_early_start: got busy=%b want 0", busy); end
    cycles(10);
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_flush_err: got %b want 0", err); end
    n_cmp++; if (obs_q.size() !== 0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_flush_out: got %0d outputs want 0", obs_q.size()); end
    clear_stats();
    pulse_start();
    wait_done(0, 200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_frame_timeout: got %0d want 1", ok); end
    n_cmp++; if (obs_q.size() !== N) begin n_fail++; $display("[TB] FAIL rst_frame_count: got %0d want %0d", obs_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("[TB] FAIL rst_frame_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_frame_err: got %b want 0", err); end
  endtask

  task automatic test_start_in_run();
    bit ok;
    clear_stats();
    win_valid = 1; out_ready = 1;
    pulse_start();
    cycles(2);
    pulse_start();
    wait_done(0, 200, ok);
    cycles(10);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL run_start_timeout: got %0d want 1", ok); end
    n_cmp++; if (fr_issues !== N) begin n_fail++; $display("[TB] FAIL run_start_issues: got %0d want %0d", fr_issues, N); end
    n_cmp++; if (obs_q.size() !== N) begin n_fail++; $display("[TB] FAIL run_start_count: got %0d want %0d", obs_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("[TB] FAIL run_start_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL run_start_done_pulses: got %0d want 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random_flow();
    test_stray_pixel();
    test_reset_midframe();
    test_start_in_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
